// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS issue queue slice.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int OREG_W  = 20;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [OREG_W-1:0]  oreg;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t WAIT = 1'b1;

endpackage

// File: rtl/mips_issue_fifo.sv
// Power-of-two circular FIFO holding queued instruction entries.
module mips_issue_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ENTRY_W-1:0]     wr_data,
    input  logic                   pop,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mips_issue_queue.sv
// Issue queue feeding a MIPS core one instruction at a time, with a response watchdog.
// Optional statistics counters are enabled by defining MIPS_ISSUE_STATS_EN.
module mips_issue_queue
    import mips_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    input  logic [31:0]            host_instr,
    input  logic [19:0]            host_oreg,
    output logic                   host_ready,
    output logic                   in_valid,
    output logic [31:0]            instruction,
    output logic [19:0]            output_reg,
    input  logic                   core_out_valid,
    input  logic                   core_fail,
    output logic                   busy,
    output logic                   timeout,
`ifdef MIPS_ISSUE_STATS_EN
    output logic [15:0]            issued_cnt,
    output logic [15:0]            fail_cnt,
`endif
    output logic [$clog2(DEPTH):0] level
);

    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             state;
    logic [WD_W-1:0]    wd_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] head_bits;
    entry_t             head;
    entry_t             wr_entry;

    assign wr_entry   = '{instr: host_instr, oreg: host_oreg};
    assign head       = entry_t'(head_bits);
    assign host_ready = !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign busy       = (state == WAIT);

    mips_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (host_valid),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            in_valid    <= 1'b0;
            timeout     <= 1'b0;
            instruction <= '0;
            output_reg  <= '0;
        end else begin
            in_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    // A stray core_out_valid here is deliberately ignored.
                    if (!fifo_empty) begin
                        state       <= WAIT;
                        wd_cnt      <= '0;
                        in_valid    <= 1'b1;
                        instruction <= head.instr;
                        output_reg  <= head.oreg;
                    end
                end
                default: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (core_out_valid) begin
                        state <= IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef MIPS_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            fail_cnt   <= '0;
        end else begin
            if (pop) issued_cnt <= issued_cnt + 1'b1;
            if (state == WAIT && core_out_valid && core_fail) fail_cnt <= fail_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_issue_queue.sv
// Directed self-checking bench for mips_issue_queue (DEPTH=4, TIMEOUT=8).
module tb_mips_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        host_valid;
    logic [31:0] host_instr;
    logic [19:0] host_oreg;
    logic        host_ready;
    logic        in_valid;
    logic [31:0] instruction;
    logic [19:0] output_reg;
    logic        core_out_valid;
    logic        core_fail;
    logic        busy;
    logic        timeout;
    logic [2:0]  level;
`ifdef MIPS_ISSUE_STATS_EN
    logic [15:0] issued_cnt;
    logic [15:0] fail_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    logic [31:0] issued[$];

    mips_issue_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_valid     (host_valid),
        .host_instr     (host_instr),
        .host_oreg      (host_oreg),
        .host_ready     (host_ready),
        .in_valid       (in_valid),
        .instruction    (instruction),
        .output_reg     (output_reg),
        .core_out_valid (core_out_valid),
        .core_fail      (core_fail),
        .busy           (busy),
        .timeout        (timeout),
`ifdef MIPS_ISSUE_STATS_EN
        .issued_cnt     (issued_cnt),
        .fail_cnt       (fail_cnt),
`endif
        .level          (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_valid) issued.push_back(instruction);
        if (timeout)  to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [19:0] o);
        host_valid = 1'b1;
        host_instr = w;
        host_oreg  = o;
    endtask

    logic [31:0] w38 [3];
    logic [19:0] o38 [3];
    logic [31:0] w37 [6];
    int          to_base;

    initial begin
        w38 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        o38 = '{20'h0_1234, 20'hA_BCDE, 20'hF_0F0F};
        w37 = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002,
                32'hC000_0003, 32'hC000_0004, 32'hC000_0005};

        rst_n = 1'b0; host_valid = 1'b0; host_instr = '0; host_oreg = '0;
        core_out_valid = 1'b0; core_fail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_valid", 32'(in_valid), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_output_reg", 32'(output_reg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd1);
        #3 rst_n = 1'b1;
        step();

        // Single-word latency
        offer(32'h20A3_0020, 20'h0_0000);
        step();
        host_valid = 1'b0;
        check("lat_level_after_push", 32'(level), 32'd1);
        check("lat_no_issue_yet", 32'(in_valid), 32'd0);
        step();
        check("lat_in_valid", 32'(in_valid), 32'd1);
        check("lat_instruction", instruction, 32'h20A3_0020);
        check("lat_output_reg", 32'(output_reg), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_level_popped", 32'(level), 32'd0);
        step();
        check("lat_pulse_one_cycle", 32'(in_valid), 32'd0);
        check("lat_busy_next", 32'(busy), 32'd1);
        check("lat_instr_hold", instruction, 32'h20A3_0020);
        core_out_valid = 1'b1;
        step();
        core_out_valid = 1'b0;
        check("lat_done_busy", 32'(busy), 32'd0);

        // Stray completion in IDLE
        core_out_valid = 1'b1;
        step();
        core_out_valid = 1'b0;
        check("idle_cov_busy", 32'(busy), 32'd0);
        check("idle_cov_in_valid", 32'(in_valid), 32'd0);
        check("idle_cov_timeout", 32'(timeout), 32'd0);

        // Three queued words answered 3 cycles after each issue
        issued.delete();
        offer(w38[0], o38[0]); step();
        offer(w38[1], o38[1]); step();
        check("ord_issue0", 32'(in_valid), 32'd1);
        check("ord_instr0", instruction, w38[0]);
        check("ord_oreg0", 32'(output_reg), 32'(o38[0]));
        offer(w38[2], o38[2]); step();
        host_valid = 1'b0;
        check("ord_level", 32'(level), 32'd2);
        check("ord_gap0", 32'(in_valid), 32'd0);
        step();
        core_out_valid = 1'b1; step(); core_out_valid = 1'b0;
        check("ord_idle_busy0", 32'(busy), 32'd0);
        check("ord_idle_iv0", 32'(in_valid), 32'd0);
        for (int k = 1; k < 3; k++) begin
            step();
            check("ord_issue", 32'(in_valid), 32'd1);
            check("ord_instr", instruction, w38[k]);
            check("ord_oreg", 32'(output_reg), 32'(o38[k]));
            step();
            step();
            core_out_valid = 1'b1; step(); core_out_valid = 1'b0;
            check("ord_idle_busy", 32'(busy), 32'd0);
            check("ord_idle_iv", 32'(in_valid), 32'd0);
        end
        check("ord_count", 32'(issued.size()), 32'd3);
        for (int k = 0; k < 3 && k < issued.size(); k++)
            check("ord_sequence", issued[k], w38[k]);

        // Overflow drop and watchdog expiry with a silent core
        issued.delete();
        to_base = to_cnt;
        offer(w37[0], 20'h0_0000); step();
        host_valid = 1'b0;
        step();
        check("ovf_blocker_issue", 32'(in_valid), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            offer(w37[i], 20'(i));
            step();
            check("ovf_ready", 32'(host_ready), (i < 4) ? 32'd1 : 32'd0);
            check("ovf_level", 32'(level), (i < 4) ? 32'(i) : 32'd4);
        end
        host_valid = 1'b0;
        step();
        step();
        check("wd_not_yet", 32'(timeout), 32'd0);
        check("wd_still_busy", 32'(busy), 32'd1);
        step();
        check("wd_pulse", 32'(timeout), 32'd1);
        check("wd_idle", 32'(busy), 32'd0);
        check("wd_no_issue", 32'(in_valid), 32'd0);
        step();
        check("wd_pulse_once", 32'(timeout), 32'd0);
        check("wd_next_issue", 32'(in_valid), 32'd1);
        check("wd_next_instr", instruction, w37[1]);
        check("ovf_level_after_issue", 32'(level), 32'd3);
        repeat (45) step();
        check("ovf_issued_count", 32'(issued.size()), 32'd5);
        for (int k = 0; k < 5 && k < issued.size(); k++)
            check("ovf_sequence", issued[k], w37[k]);
        check("ovf_drained", 32'(level), 32'd0);
        check("ovf_timeouts", 32'(to_cnt - to_base), 32'd5);

        // Reset during WAIT with two words queued
        offer(32'hAAAA_0001, 20'h1_1111); step();
        offer(32'hAAAA_0002, 20'h2_2222); step();
        offer(32'hAAAA_0003, 20'h3_3333); step();
        host_valid = 1'b0;
        check("mid_level", 32'(level), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_valid", 32'(in_valid), 32'd0);
        check("mid_rst_instruction", instruction, 32'd0);
        check("mid_rst_output_reg", 32'(output_reg), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        step();
        #2 rst_n = 1'b1;
        core_out_valid = 1'b1; step(); core_out_valid = 1'b0;
        check("post_rst_cov_busy", 32'(busy), 32'd0);
        check("post_rst_cov_level", 32'(level), 32'd0);
        offer(32'h5555_AAAA, 20'h5_A5A5); step();
        host_valid = 1'b0;
        step();
        check("post_rst_issue", 32'(in_valid), 32'd1);
        check("post_rst_instr", instruction, 32'h5555_AAAA);
        check("post_rst_oreg", 32'(output_reg), 32'h5_A5A5);
        core_out_valid = 1'b1; step(); core_out_valid = 1'b0;
        check("post_rst_done", 32'(busy), 32'd0);

`ifdef MIPS_ISSUE_STATS_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("st_rst_issued", 32'(issued_cnt), 32'd0);
        check("st_rst_fail", 32'(fail_cnt), 32'd0);
        offer(32'hB000_0000, 20'h0); step();
        offer(32'hB000_0001, 20'h1); step();
        offer(32'hB000_0002, 20'h2); step();
        offer(32'hB000_0003, 20'h3); step();
        host_valid = 1'b0;
        core_out_valid = 1'b1; core_fail = 1'b1; step();
        core_out_valid = 1'b0; core_fail = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            check("st_issue", 32'(in_valid), 32'd1);
            core_out_valid = 1'b1; core_fail = (k == 1); step();
            core_out_valid = 1'b0; core_fail = 1'b0;
        end
        check("st_issued_cnt", 32'(issued_cnt), 32'd4);
        check("st_fail_cnt", 32'(fail_cnt), 32'd2);
        core_out_valid = 1'b1; core_fail = 1'b1; step();
        core_out_valid = 1'b0; core_fail = 1'b0;
        check("st_idle_issued", 32'(issued_cnt), 32'd4);
        check("st_idle_fail", 32'(fail_cnt), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_issue_queue.md
MIPS_ISSUE_QUEUE -- requirements
Module: mips_issue_queue

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, 1023, max cycles spent waiting for a core response.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 host_valid  input  1  host offers one instruction word.
REQ-006 host_instr  input  32  instruction word offered by the host.
REQ-007 host_oreg  input  20  four 5-bit output-register selectors travelling with the instruction.
REQ-008 host_ready  output  1  queue can accept an entry this cycle.
REQ-009 in_valid  output  1  one-cycle issue strobe to the core.
REQ-010 instruction  output  32  issued instruction word; valid while in_valid=1.
REQ-011 output_reg  output  20  issued selectors; valid while in_valid=1.
REQ-012 core_out_valid  input  1  core completion strobe.
REQ-013 core_fail  input  1  core instruction_fail; sampled only when core_out_valid=1.
REQ-014 busy  output  1  an instruction is outstanding in the core.
REQ-015 timeout  output  1  one-cycle pulse on watchdog expiry.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Push: host_valid&&host_ready at a posedge writes {host_instr,host_oreg} at the tail.
REQ-018 host_ready = (level<DEPTH), combinational from registered count; a push offered while full is dropped, with no state change.
REQ-019 FSM states are IDLE, WAIT; reset state IDLE.
REQ-020 IDLE with level>0 at a posedge: pop head, register it onto instruction/output_reg, set in_valid=1 for exactly one cycle, and go to WAIT.
REQ-021 Latency: a word pushed into an empty queue in IDLE appears with in_valid=1 in the second cycle after the push edge.
REQ-022 WAIT: busy=1; in_valid=0; the FIFO keeps accepting pushes; no further pop.
REQ-023 WAIT with core_out_valid=1 returns to IDLE at the next posedge; the next pop can occur at the following edge, so issues are at least 2 cycles apart after completion.
REQ-024 The watchdog counter clears on entry to WAIT and increments each WAIT cycle; when it reaches TIMEOUT without core_out_valid, the FSM returns to IDLE and timeout pulses for one cycle.
REQ-025 A core_out_valid arriving in IDLE is ignored, with no counter or state change.
REQ-026 A simultaneous push and pop leaves level unchanged; a push and pop in the same cycle when level=DEPTH is impossible because host_ready=0.
REQ-027 instruction/output_reg hold their last issued value when in_valid=0.
REQ-028 Read and write pointers wrap modulo DEPTH.

Reset
REQ-029 rst_n low: FIFO emptied (pointers and level 0), state IDLE, in_valid=0, instruction=0, output_reg=0, busy=0, timeout=0, watchdog=0, statistics counters 0.
REQ-030 Reset asserted mid-WAIT abandons the outstanding instruction, and any core_out_valid arriving after reset release is ignored (REQ-025).
REQ-031 FIFO storage array contents need no reset.

Configuration
REQ-032 With MIPS_ISSUE_STATS_EN defined: outputs issued_cnt[15:0] (increments per in_valid) and fail_cnt[15:0] (increments per core_out_valid&&core_fail in WAIT), both wrapping at 16 bits.
REQ-033 With MIPS_ISSUE_STATS_EN undefined: these ports and counters are absent, and all other behaviour is identical.

Structure
REQ-034 Package mips_pkg holds the FSM state typedef, the entry struct {instr[31:0], oreg[19:0]}, and localparams INSTR_W=32 and OREG_W=20.
REQ-035 The FIFO is the sub-module mips_issue_fifo (parameter DEPTH; push/pop/full/empty/level); the FSM, watchdog and statistics live in the top.

Verification
REQ-036 Reset, then push 0x20A30020/oreg 0x00000 into an empty queue -> in_valid is high in the second cycle after the push edge, carrying that word; busy=1 from the next cycle.
REQ-037 DEPTH=4: push 5 words back-to-back while the core never responds -> host_ready=0 after the 4th accepted push, the 5th word is dropped, level=3 after the first issue, and the 5th word is never issued.
REQ-038 Pulse core_out_valid 3 cycles after each issue with 3 queued words -> exactly 3 in_valid pulses, issued in FIFO order, with no overlap with busy re-entry.
REQ-039 With TIMEOUT=8 and no core response -> timeout pulses once, the FSM returns to IDLE, and the next queued word issues on the following edge.
REQ-040 With MIPS_ISSUE_STATS_EN, issue 4 words and answer 2 with core_fail=1 -> issued_cnt=4 and fail_cnt=2; a core_out_valid injected in IDLE leaves the counts unchanged.
REQ-041 Assert rst_n low during WAIT with 2 words queued -> all outputs are 0 and level=0; after release, the next push issues normally.
